// File: rtl/filtered_pulse_detection_pkg.sv
// Shared constants and counter type for the filtered falling-edge detector.
// Defaults: 8-sample debounce window, 8-bit event counter.
package pulse_detection_pkg;
  localparam int PD_FILTER_LEN_DEFAULT = 8;
  localparam int PD_CNT_WIDTH_DEFAULT  = 8;

  typedef logic [PD_CNT_WIDTH_DEFAULT-1:0] pd_cnt_t;
endpackage

// File: rtl/filtered_pulse_detection_if.sv
// Level input plus pulse/count outputs of the detector; slave side is the detector.
// No handshake: d is sampled every cycle, q and Pulse_Counter are registered.
interface filtered_pulse_detection_if #(
  parameter int CNT_WIDTH = pulse_detection_pkg::PD_CNT_WIDTH_DEFAULT
) ();
  logic                 d;
  logic                 q;
  logic [CNT_WIDTH-1:0] Pulse_Counter;

  modport master (output d, input q, input Pulse_Counter);
  modport slave  (input d, output q, output Pulse_Counter);
endinterface

// File: rtl/filtered_pulse_detection_glitch_filter.sv
// Debounce: filt follows d_s only after FILTER_LEN consecutive differing samples.
// fall is a combinational strobe for the update where filt goes 1 -> 0.
module glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic d_s,
  output logic filt,
  output logic fall
);
  localparam int                RUN_W    = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(FILTER_LEN - 1);

  logic [RUN_W-1:0] r_run;
  logic             r_filt;
  logic             w_done;

  assign w_done = (d_s != r_filt) && (r_run == RUN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run  <= '0;
      r_filt <= 1'b0;
    end else if (d_s == r_filt) begin
      r_run  <= '0;
    end else if (r_run == RUN_LAST) begin
      r_filt <= d_s;
      r_run  <= '0;
    end else begin
      r_run  <= r_run + 1'b1;
    end
  end

  assign filt = r_filt;
  assign fall = w_done && r_filt;
endmodule

// File: rtl/filtered_pulse_detection.sv
// Debounced falling-edge detector with wrapping event counter; q/count update FILTER_LEN
// edges after d first samples low (+1 with PULSE_DETECT_SYNC_EN, which adds a 2-flop synchronizer).
module filtered_pulse_detection import pulse_detection_pkg::*; #(
  parameter int FILTER_LEN = PD_FILTER_LEN_DEFAULT,
  parameter int CNT_WIDTH  = PD_CNT_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  filtered_pulse_detection_if.slave  pd
);
  logic                 r_d_s;
  logic                 r_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_filt;
  logic                 w_fall;

`ifdef PULSE_DETECT_SYNC_EN
  logic r_d_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_meta <= 1'b0;
      r_d_s    <= 1'b0;
    end else begin
      r_d_meta <= pd.d;
      r_d_s    <= r_d_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_s <= 1'b0;
    end else begin
      r_d_s <= pd.d;
    end
  end
`endif

  glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk   (clk),
    .reset (reset),
    .d_s   (r_d_s),
    .filt  (w_filt),
    .fall  (w_fall)
  );

  // Event is tied to the filtered level actually leaving 1 on this update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_q <= w_fall && w_filt;
      if (w_fall && w_filt) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign pd.q             = r_q;
  assign pd.Pulse_Counter = r_cnt;
endmodule

// File: tb/tb_filtered_pulse_detection.sv
// Directed stimulus for filtered_pulse_detection; expected pulses (cycle, count) go to a
// scoreboard queue and a negedge monitor pops and compares each q pulse.
module tb_filtered_pulse_detection;
  import pulse_detection_pkg::*;

  localparam int FL = PD_FILTER_LEN_DEFAULT;
`ifdef PULSE_DETECT_SYNC_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int      cyc;
    pd_cnt_t cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  filtered_pulse_detection_if #(.CNT_WIDTH(PD_CNT_WIDTH_DEFAULT)) pd_if ();

  filtered_pulse_detection #(
    .FILTER_LEN (FL),
    .CNT_WIDTH  (PD_CNT_WIDTH_DEFAULT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pd    (pd_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every q pulse must match the oldest expected pulse.
  always @(negedge clk) begin
    exp_t e;
    if (pd_if.q === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: q high at cycle %0d with count %0d, expected no pulse",
                 cyc, pd_if.Pulse_Counter);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_count", int'(pd_if.Pulse_Counter), int'(e.cnt));
      end
    end
  end

  // Hold d at lvl for n rising edges; if a pulse is expected, the first low sample
  // lands on the next edge and q appears FL (+LAT) edges after that.
  task automatic seg(input logic lvl, input int n, input bit exp_p, input int exp_c);
    exp_t e;
    @(negedge clk);
    if (exp_p) begin
      e.cyc = cyc + 1 + FL + LAT;
      e.cnt = pd_cnt_t'(exp_c);
      sb.push_back(e);
    end
    pd_if.d = lvl;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int exp_q, input int exp_c);
    check({tag, "_q"},   int'(pd_if.q), exp_q);
    check({tag, "_cnt"}, int'(pd_if.Pulse_Counter), exp_c);
  endtask

  initial begin
    reset    = 1'b1;
    pd_if.d  = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("reset", 0, 0);
    reset = 1'b0;

    // Basic long high then long low.
    seg(1'b1, 20, 0, 0);
    seg(1'b0, 20, 1, 1);
    // 3-cycle low glitch is discarded.
    seg(1'b1, 20, 0, 0);
    seg(1'b0, 3,  0, 0);
    seg(1'b1, 20, 0, 0);
    chk_out("glitch", 0, 1);
    // Second genuine edge, then another glitch.
    seg(1'b0, 20, 1, 2);
    seg(1'b1, 20, 0, 0);
    seg(1'b0, 3,  0, 0);
    seg(1'b1, 20, 0, 0);
    chk_out("glitch2", 0, 2);
    // Boundary: 7 low samples rejected, exactly 8 accepted.
    seg(1'b0, 7,  0, 0);
    seg(1'b1, 20, 0, 0);
    chk_out("low7", 0, 2);
    seg(1'b0, 8,  1, 3);
    seg(1'b1, 20, 0, 0);
    chk_out("low8", 0, 3);

    // Reset in the middle of a low run aborts it.
    seg(1'b0, 4, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_out("midreset", 0, 0);
    seg(1'b0, 4,  0, 0);
    seg(1'b1, 20, 0, 0);
    seg(1'b0, 20, 1, 1);

    // 255 more edges: the 256th since reset wraps the count to 0.
    for (int i = 1; i <= 255; i++) begin
      seg(1'b1, 10, 0, 0);
      seg(1'b0, 10, 1, (i + 1) % 256);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    chk_out("final", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/filtered_pulse_detection.md
# filtered_pulse_detection

Filter-protected negative-edge detector with a running count of detected edges. It debounces a single-bit input `d`, emits a one-cycle pulse on `q` for each qualified high-to-low transition, and keeps an 8-bit count of those events in `Pulse_Counter`. It sits between a noisy or slow level input and downstream logic that must see exactly one event per genuine falling edge.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples needed before the filtered level changes; legal range 2..255.
- `CNT_WIDTH`, default 8: width of `Pulse_Counter`.
- `clk` input 1: the single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high reset.
- `d` input 1: raw level input.
- `q` output 1: one-cycle pulse per qualified falling edge.
- `Pulse_Counter` output CNT_WIDTH: number of qualified falling edges since reset.

## Operation
- Sample path: `d` is registered into `d_s` every cycle; with `PULSE_DETECT_SYNC_EN`, through two flops instead of one.
- Filter state:
  - `filt` is the debounced level, reset to 0.
  - `run` is a run counter, reset to 0, of width clog2(FILTER_LEN+1).
- Each cycle, while not in reset:
  - If `d_s` == `filt`: `run` <= 0.
  - Else if `run` == FILTER_LEN-1: `filt` <= `d_s` and `run` <= 0.
  - Else: `run` <= `run`+1.
- A filtered change therefore needs FILTER_LEN consecutive samples differing from `filt`. Any shorter excursion, such as a 3-cycle low glitch, is discarded and `run` restarts.
- Qualified falling edge: the update where `filt` goes 1→0.
  - `q` <= 1 for exactly that one cycle; otherwise `q` <= 0.
  - `Pulse_Counter` <= `Pulse_Counter`+1 on the same edge.
- Rising filtered transitions (0→1) never pulse or count.
- Counter arithmetic: modulo 2^CNT_WIDTH, so 255+1 wraps to 0. No saturation and no overflow flag.
- Because `filt` resets to 0, a low `d` after reset produces no pulse. A pulse requires a filtered high followed by a filtered low.

## Timing
- Reset is synchronous and overrides everything. The cycle after `reset` is seen high: `q`=0, `Pulse_Counter`=0, `filt`=0, `run`=0, and the sync flops are 0.
- Reset asserted mid-filter aborts the pending transition. No pulse is produced for it.
- Latency, without the macro: `d` first low at rising edge k, with `filt`=1 and `d` held low, gives `q`=1 and the count update visible after edge k+FILTER_LEN. With the macro, add one cycle.
- `q` is high for exactly one clock per event.
- The minimum spacing between pulses is 2·FILTER_LEN cycles, because a full high run and a full low run are both required.
- A `d` toggling faster than FILTER_LEN cycles leaves `filt`, `q` and `Pulse_Counter` unchanged indefinitely.
- All outputs are registered. There is no combinational path from `d` to any output.

## Configuration
- `PULSE_DETECT_SYNC_EN` defined: `d` passes through a 2-flop synchronizer before the filter, for asynchronous sources. Latency is +1 cycle.
- `PULSE_DETECT_SYNC_EN` undefined: a single input register, for `d` already synchronous to `clk`.

## Structure
- Package `pulse_detection_pkg` holds:
  - default constants `PD_FILTER_LEN_DEFAULT` = 8 and `PD_CNT_WIDTH_DEFAULT` = 8;
  - the `pd_cnt_t` counter typedef.
- Sub-module `glitch_filter`:
  - ports: `clk`, `reset`, `d_s`, parameter `FILTER_LEN`;
  - outputs `filt` and a one-cycle `fall` strobe.
- The top level contains the input register or synchronizer, instantiates `glitch_filter`, and holds the `q` and `Pulse_Counter` registers.

## Test plan
- Reset, then `d`=1 for 20 cycles, then `d`=0 for 20 cycles: exactly one `q` pulse, FILTER_LEN+1 cycles after the fall; `Pulse_Counter`=1.
- Then `d`=1 for 20, `d`=0 for 3, then `d`=1 again: no pulse; `Pulse_Counter` stays 1.
- Repeat the 20-high/20-low pattern: second pulse; `Pulse_Counter`=2. The 3-cycle low that follows adds nothing.
- Boundary with FILTER_LEN=8:
  - a low run of 7 cycles after a long high gives no pulse;
  - a low run of exactly 8 cycles gives one pulse.
- Assert `reset` for 1 cycle midway through an 8-cycle low run: no pulse; outputs 0 next cycle; a fresh high then low sequence counts from 1.
- 256 qualified falling edges: `Pulse_Counter` goes 255 → 0 on the 256th, and `q` still pulses.
